instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage of the five-stage MIPS pipeline. It owns the program counter, the instruction memory and its sequential loader, and the next-PC selection. It produces the fetched instruction and PC+4 that feed the IF/ID pipeline register. A three-state controller (LOAD, RUN, HALTED) gates fetching and stops the stage when the HALT word is fetched.

## Interface
- PC_SIZE, 32, program counter width (byte address)
- BUS_SIZE, 32, instruction width
- MEM_DEPTH, 64, instruction memory depth in words
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_enable  in  1  debug-unit run/step enable; PC advances only when high
- i_stall  in  1  hazard-unit stall; holds PC when high
- i_pc_src  in  2  next-PC select: 00 sequential, 01 branch, 10 jump, 11 treated as sequential
- i_branch_addr  in  PC_SIZE  branch target from ID
- i_jump_addr  in  PC_SIZE  jump target from ID
- i_load_valid  in  1  loader write strobe
- i_load_data  in  BUS_SIZE  word to load
- i_start  in  1  LOAD to RUN request
- i_clear  in  1  synchronous return to LOAD
- o_next_seq_pc  out  PC_SIZE  PC+4
- o_instruction  out  BUS_SIZE  word at current PC
- o_halt  out  1  high in HALTED
- o_load_full  out  1  loader count equals MEM_DEPTH
- o_running  out  1  high in RUN

## Operation
- State LOAD:
  - i_load_valid with count < MEM_DEPTH writes mem[count] and increments count.
  - i_load_valid when full is ignored. Memory and count are unchanged.
  - PC is held at 0.
  - i_start moves to RUN.
- State RUN: advance = i_enable & ~i_stall. On advance:
  - PC gets PC+4, i_branch_addr or i_jump_addr per i_pc_src.
  - If o_instruction equals HALT (32'hFFFF_FFFF), PC is held and the state moves to HALTED.
- State HALTED: PC is frozen and o_halt=1. Only i_clear or reset leaves this state.
- i_clear, in any state: state goes to LOAD, PC=0, count=0. Memory contents are not erased.
- Read path:
  - Combinational read of mem[PC[log2(MEM_DEPTH)+1:2]]. PC[1:0] is ignored.
  - Word index ≥ count or ≥ MEM_DEPTH returns HALT. The stage therefore halts when execution runs past the loaded program.
- o_next_seq_pc = PC+4, modulo 2^PC_SIZE. Wrap-around is natural and not flagged.
- Priority: reset > i_clear > i_start/load > stall > pc_src.
  - A branch or jump presented during a stall is lost. The hazard unit holds i_pc_src.

## Timing
- Reset values:
  - State LOAD, PC=0, count=0.
  - o_next_seq_pc=4, o_instruction=HALT, o_halt=0, o_load_full=0, o_running=0.
- Loaded words are readable the cycle after the write edge.
- i_load_valid together with i_start in the same cycle: the word is written and the state becomes RUN on the same edge. First fetch is at PC=0 in the next cycle.
- PC update, branch or jump: one-cycle latency. The target instruction appears on o_instruction the cycle after the edge.
- HALT fetched while advance=0: no transition until the first cycle with advance=1.
- o_halt rises on the edge that consumes HALT. PC stays at the HALT address.
- i_clear during RUN or HALTED takes effect on the next edge. The in-flight instruction is not invalidated here; downstream flush is ID's responsibility.
- i_start in RUN or HALTED is ignored.

## Structure
- Shared header instruction_fetch.vh:
  - DEFAULT_PC_SIZE and DEFAULT_ID_BUS_SIZE (shared with if_id).
  - HALT encoding.
  - PC_SRC_SEQ/BRANCH/JUMP codes.
  - State encodings ST_LOAD/ST_RUN/ST_HALTED.
  - CLEAR macro.
- Sub-module instruction_memory:
  - MEM_DEPTH × BUS_SIZE.
  - Synchronous write, asynchronous read.
  - No reset on the array.
- Top level: FSM, PC register, load counter, next-PC mux and out-of-range HALT substitution.

## Test plan
- Reset, then release: o_instruction=FFFF_FFFF, o_next_seq_pc=4, o_halt=0. Then i_start with no load: HALTED after one advance.
- Load 3 words (ADDI, ADDI, HALT), i_start, i_enable=1: PC 0→4→8, then o_halt=1 with PC=8 frozen.
- RUN with i_pc_src=01, i_branch_addr=0x20, i_stall=1 for 2 cycles, then 0: PC holds 2 cycles, then becomes 0x20. o_next_seq_pc=0x24.
- Load MEM_DEPTH+2 words: o_load_full=1 after 64 writes, last two ignored, mem[0] intact.
- i_clear in HALTED: LOAD, PC=0, count=0, o_halt=0. Reload 1 word + i_start same cycle: fetch at PC=0 returns the new word.
- Assert i_reset low mid-RUN at PC=0x10: all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared constants and types for the MIPS instruction fetch stage.
package instruction_fetch_pkg;

  // Default widths, also used by the IF/ID pipeline register.
  localparam int DEFAULT_PC_SIZE     = 32;
  localparam int DEFAULT_ID_BUS_SIZE = 32;

  // Reserved encoding that stops the stage when it is fetched.
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  // Next-PC select codes. 2'b11 falls back to sequential.
  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/instruction_memory.sv
// Instruction memory: synchronous write from the loader, asynchronous read
// for fetch. The array is deliberately not reset.
module instruction_memory
  import instruction_fetch_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = DEFAULT_ID_BUS_SIZE,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Loader write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: program counter, sequential program loader,
// next-PC selection and the LOAD/RUN/HALTED controller.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_LOAD   | PC held at 0, loader writes words at mem[count]
//   ST_RUN    | fetch; PC advances on enable & ~stall, HALT word -> HALTED
//   ST_HALTED | PC frozen, o_halt high; only clear or reset leaves
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int PC_SIZE   = DEFAULT_PC_SIZE,
  parameter int BUS_SIZE  = DEFAULT_ID_BUS_SIZE,
  parameter int MEM_DEPTH = 64
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_stall,
  input  logic [1:0]          i_pc_src,
  input  logic [PC_SIZE-1:0]  i_branch_addr,
  input  logic [PC_SIZE-1:0]  i_jump_addr,
  input  logic                i_load_valid,
  input  logic [BUS_SIZE-1:0] i_load_data,
  input  logic                i_start,
  input  logic                i_clear,
  output logic [PC_SIZE-1:0]  o_next_seq_pc,
  output logic [BUS_SIZE-1:0] o_instruction,
  output logic                o_halt,
  output logic                o_load_full,
  output logic                o_running
);

  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam int CNT_W  = $clog2(MEM_DEPTH + 1);
  localparam logic [BUS_SIZE-1:0] HALT      = '1;
  localparam logic [CNT_W-1:0]    DEPTH_CNT = CNT_W'(MEM_DEPTH);

  state_t              state, state_next;
  logic [PC_SIZE-1:0]  pc, pc_next, seq_pc;
  logic [CNT_W-1:0]    count, count_next;
  logic                mem_we;
  logic [BUS_SIZE-1:0] mem_rdata;
  logic                full, in_range, advance, fetched_halt;

  instruction_memory #(
    .DEPTH  (MEM_DEPTH),
    .WIDTH  (BUS_SIZE),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (i_clk),
    .we    (mem_we),
    .waddr (count[ADDR_W-1:0]),
    .wdata (i_load_data),
    .raddr (pc[ADDR_W+1:2]),
    .rdata (mem_rdata)
  );

  assign seq_pc  = pc + PC_SIZE'(4);
  assign full    = (count == DEPTH_CNT);
  assign advance = i_enable & ~i_stall;

  // The full word index is compared, so addresses beyond the array never
  // alias back onto loaded words. count <= MEM_DEPTH covers both bounds.
  assign in_range      = (pc[PC_SIZE-1:2] < (PC_SIZE-2)'(count));
  assign o_instruction = in_range ? mem_rdata : HALT;
  assign fetched_halt  = (o_instruction == HALT);

  assign o_next_seq_pc = seq_pc;
  assign o_halt        = (state == ST_HALTED);
  assign o_running     = (state == ST_RUN);
  assign o_load_full   = full;

  // State, PC and loader count registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= ST_LOAD;
      pc    <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      count <= count_next;
    end
  end

  // Next state, next PC, loader write strobe; clear overrides everything.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    count_next = count;
    mem_we     = 1'b0;
    if (i_clear) begin
      state_next = ST_LOAD;
      pc_next    = '0;
      count_next = '0;
    end else begin
      case (state)
        ST_LOAD: begin
          pc_next = '0;
          if (i_load_valid && !full) begin
            mem_we     = 1'b1;
            count_next = count + CNT_W'(1);
          end
          if (i_start) state_next = ST_RUN;
        end
        ST_RUN: begin
          if (advance) begin
            if (fetched_halt) begin
              state_next = ST_HALTED;
            end else begin
              case (i_pc_src)
                PC_SRC_BRANCH: pc_next = i_branch_addr;
                PC_SRC_JUMP:   pc_next = i_jump_addr;
                default:       pc_next = seq_pc;
              endcase
            end
          end
        end
        ST_HALTED: begin
          pc_next = pc;
        end
        default: begin
          state_next = ST_LOAD;
          pc_next    = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the stage.
module tb_instruction_fetch;

  localparam int          DEPTH  = 64;
  localparam logic [31:0] HALT   = 32'hFFFF_FFFF;
  localparam int          M_LOAD = 0;
  localparam int          M_RUN  = 1;
  localparam int          M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, stall, load_valid, start, clear;
  logic [1:0]  pc_src;
  logic [31:0] branch_addr, jump_addr, load_data;
  logic [31:0] next_seq_pc, instruction;
  logic        halt, load_full, running;

  int checks = 0;
  int errors = 0;

  // Behavioural model: program image, loaded word count, PC, mode.
  logic [31:0] mem_m [DEPTH];
  int          cnt_m;
  logic [31:0] pc_m;
  int          st_m;

  instruction_fetch #(
    .PC_SIZE   (32),
    .BUS_SIZE  (32),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_enable      (enable),
    .i_stall       (stall),
    .i_pc_src      (pc_src),
    .i_branch_addr (branch_addr),
    .i_jump_addr   (jump_addr),
    .i_load_valid  (load_valid),
    .i_load_data   (load_data),
    .i_start       (start),
    .i_clear       (clear),
    .o_next_seq_pc (next_seq_pc),
    .o_instruction (instruction),
    .o_halt        (halt),
    .o_load_full   (load_full),
    .o_running     (running)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_instr();
    int idx;
    idx = int'(pc_m >> 2);
    if (idx < cnt_m && idx < DEPTH) return mem_m[idx];
    return HALT;
  endfunction

  task automatic model_reset();
    st_m  = M_LOAD;
    pc_m  = 32'd0;
    cnt_m = 0;
  endtask

  task automatic idle();
    enable      = 1'b0;
    stall       = 1'b0;
    load_valid  = 1'b0;
    start       = 1'b0;
    clear       = 1'b0;
    pc_src      = 2'b00;
    branch_addr = 32'd0;
    jump_addr   = 32'd0;
    load_data   = 32'd0;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] e_instr, e_seq;
    logic        e_halt, e_full, e_run;
    e_instr = exp_instr();
    e_seq   = pc_m + 32'd4;
    e_halt  = (st_m == M_HALT);
    e_run   = (st_m == M_RUN);
    e_full  = (cnt_m == DEPTH);
    checks++;
    assert (instruction === e_instr) else begin
      errors++;
      $error("FAIL %s instruction: got %h expected %h", tag, instruction, e_instr);
    end
    checks++;
    assert (next_seq_pc === e_seq) else begin
      errors++;
      $error("FAIL %s next_seq_pc: got %h expected %h", tag, next_seq_pc, e_seq);
    end
    checks++;
    assert (halt === e_halt) else begin
      errors++;
      $error("FAIL %s halt: got %b expected %b", tag, halt, e_halt);
    end
    checks++;
    assert (running === e_run) else begin
      errors++;
      $error("FAIL %s running: got %b expected %b", tag, running, e_run);
    end
    checks++;
    assert (load_full === e_full) else begin
      errors++;
      $error("FAIL %s load_full: got %b expected %b", tag, load_full, e_full);
    end
  endtask

  // One clock: predict the effect of the current inputs, take the edge, check.
  task automatic tick(input string tag);
    logic [31:0] cur, npc;
    int          ns, ncnt;
    cur  = exp_instr();
    ns   = st_m;
    npc  = pc_m;
    ncnt = cnt_m;
    if (clear) begin
      ns   = M_LOAD;
      npc  = 32'd0;
      ncnt = 0;
    end else if (st_m == M_LOAD) begin
      if (load_valid && cnt_m < DEPTH) begin
        mem_m[cnt_m] = load_data;
        ncnt         = cnt_m + 1;
      end
      if (start) ns = M_RUN;
    end else if (st_m == M_RUN && enable && !stall) begin
      if (cur == HALT)          ns  = M_HALT;
      else if (pc_src == 2'b01) npc = branch_addr;
      else if (pc_src == 2'b10) npc = jump_addr;
      else                      npc = pc_m + 32'd4;
    end
    @(posedge clk);
    #1;
    st_m  = ns;
    pc_m  = npc;
    cnt_m = ncnt;
    check_all(tag);
  endtask

  task automatic load_word(input logic [31:0] w, input string tag);
    load_valid = 1'b1;
    load_data  = w;
    tick(tag);
    load_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    idle();
    model_reset();
    rst_n = 1'b0;
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick("post_reset");

    // Start with nothing loaded: the first fetch is HALT.
    start = 1'b1;
    tick("empty_start");
    start  = 1'b0;
    enable = 1'b1;
    tick("empty_halt");
    tick("empty_halt_hold");
    idle();

    // ADDI, ADDI, HALT program.
    clear = 1'b1;
    tick("clear1");
    clear = 1'b0;
    load_word(32'h2001_0001, "load_addi0");
    load_word(32'h2002_0002, "load_addi1");
    load_word(HALT, "load_halt");
    start = 1'b1;
    tick("prog_start");
    start  = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) tick("prog_run");
    idle();

    // Branch held off by a two-cycle stall.
    clear = 1'b1;
    tick("clear2");
    clear = 1'b0;
    for (int i = 0; i < 10; i++) load_word(32'h2000_0000 + i, "load_br");
    start = 1'b1;
    tick("br_start");
    start       = 1'b0;
    enable      = 1'b1;
    pc_src      = 2'b01;
    branch_addr = 32'h20;
    stall       = 1'b1;
    tick("br_stall0");
    tick("br_stall1");
    stall = 1'b0;
    tick("br_taken");
    pc_src = 2'b11;
    tick("br_src11_seq");
    idle();

    // Overfill the loader; the extra words are dropped.
    clear = 1'b1;
    tick("clear3");
    clear = 1'b0;
    load_word(32'hA5A5_0000, "fill_first");
    for (int i = 1; i < DEPTH + 2; i++) load_word($urandom() & 32'h7FFF_FFFF, "fill");
    tick("fill_hold");

    // Jump to the top of the address space: next_seq_pc wraps, fetch is HALT.
    start = 1'b1;
    tick("jmp_start");
    start     = 1'b0;
    enable    = 1'b1;
    pc_src    = 2'b10;
    jump_addr = 32'hFFFF_FFFC;
    tick("jmp_wrap");
    tick("jmp_halt");
    idle();

    // Clear out of HALTED, then load one word and start in the same cycle.
    clear = 1'b1;
    tick("clear_halted");
    clear      = 1'b0;
    load_valid = 1'b1;
    load_data  = 32'h1234_5678;
    start      = 1'b1;
    tick("load_and_start");
    idle();
    tick("new_word_fetch");

    // Asynchronous reset in the middle of a run at PC 0x10.
    clear = 1'b1;
    tick("clear4");
    clear = 1'b0;
    for (int i = 0; i < 8; i++) load_word(32'h0000_1000 + i, "load_rst");
    start = 1'b1;
    tick("rst_start");
    start  = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) tick("rst_run");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    tick("after_async_reset");

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      clear       = ($urandom_range(0, 49) == 0);
      start       = ($urandom_range(0, 19) == 0);
      load_valid  = ($urandom_range(0, 1) == 0);
      enable      = ($urandom_range(0, 4) != 0);
      stall       = ($urandom_range(0, 4) == 0);
      pc_src      = 2'($urandom_range(0, 3));
      branch_addr = (32'($urandom_range(0, 40)) << 2) | 32'($urandom_range(0, 3));
      jump_addr   = (32'($urandom_range(0, 40)) << 2) | 32'($urandom_range(0, 3));
      d = $urandom();
      if ($urandom_range(0, 19) == 0) d = HALT;
      load_data = d;
      tick("random");
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
